// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core requesters (fetch, load/store), the arbiter and memory.
// slave : arbiter view (takes requests, drives grants/responses and memory request)
// master: environment view (drives requests and memory responses)
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_gnt;
    logic        if_rvalid;

    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_be;
    logic        ls_gnt;
    logic        ls_rvalid;

    logic [31:0] rdata;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, if_flush,
        output if_gnt, if_rvalid,
        input  ls_req, ls_we, ls_addr, ls_wdata, ls_be,
        output ls_gnt, ls_rvalid,
        output rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport master (
        output if_req, if_addr, if_flush,
        input  if_gnt, if_rvalid,
        output ls_req, ls_we, ls_addr, ls_wdata, ls_be,
        input  ls_gnt, ls_rvalid,
        input  rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch / load-store arbiter in front of a single-ported memory, one transaction in flight.
// Ports: clk, rst (async, active-high), bus (mem_arbiter_if.slave: requesters + memory).
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic        owner_if_q, owner_if_d;
    logic [2:0]  streak_q, streak_d;
    logic        drop_q, drop_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic        pick_if;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_if_q  <= 1'b0;
            streak_q    <= 3'd0;
            drop_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_be_q    <= 4'd0;
        end else begin
            state_q     <= state_d;
            owner_if_q  <= owner_if_d;
            streak_q    <= streak_d;
            drop_q      <= drop_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_if_d    = owner_if_q;
        streak_d      = streak_q;
        drop_d        = drop_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_be_d      = mem_be_q;
        bus.if_gnt    = 1'b0;
        bus.ls_gnt    = 1'b0;
        bus.if_rvalid = 1'b0;
        bus.ls_rvalid = 1'b0;

        // Load/store normally wins; fetch forces its way in once starved.
        pick_if = bus.if_req && (!bus.ls_req || streak_q == LIMIT);

        unique case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                if (!bus.if_req) begin
                    streak_d = 3'd0;
                end
                if (bus.if_req || bus.ls_req) begin
                    state_d    = REQ;
                    owner_if_d = pick_if;
                    if (pick_if) begin
                        streak_d    = 3'd0;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = bus.if_addr;
                        mem_wdata_d = 32'd0;
                        mem_be_d    = 4'hF;
                    end else begin
                        // Streak only grows while fetch is actually waiting.
                        if (bus.if_req) begin
                            streak_d = streak_q + 3'd1;
                        end
                        mem_we_d    = bus.ls_we;
                        mem_addr_d  = bus.ls_addr;
                        mem_wdata_d = bus.ls_wdata;
                        mem_be_d    = bus.ls_be;
                    end
                end
            end
            REQ: begin
                if (owner_if_q && bus.if_flush) begin
                    drop_d = 1'b1;
                end
                if (bus.mem_gnt) begin
                    bus.if_gnt = owner_if_q;
                    bus.ls_gnt = !owner_if_q;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (owner_if_q && bus.if_flush) begin
                    drop_d = 1'b1;
                end
                if (bus.mem_rvalid) begin
                    // A flush in the response cycle itself also kills the data.
                    bus.if_rvalid = owner_if_q && !drop_q && !bus.if_flush;
                    bus.ls_rvalid = !owner_if_q;
                    drop_d        = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.mem_req   = (state_q == REQ);
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.rdata     = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int LIMIT = 4;
    localparam int NV    = 21;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int n;

    typedef struct {
        logic        ifr;
        logic        lsr;
        logic        we;
        logic        fl;
        logic        mg;
        logic        mv;
        logic [31:0] ls_addr;
        logic [3:0]  ls_be;
        logic [4:0]  exp;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [3:0]  exp_be;
    } vec_t;

    vec_t vecs [NV];

    // Reference model: the one transaction the arbiter should currently own.
    bit          m_busy, m_granted, m_own_if, m_dropped;
    int          m_streak;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    logic        m_we;
    bit          if_hold, ls_hold;
    logic [4:0]  e;

    function automatic logic [4:0] outs();
        return {bus.mem_req, bus.if_gnt, bus.ls_gnt, bus.if_rvalid, bus.ls_rvalid};
    endfunction

    task automatic chk(input string nm, input logic [68:0] got, input logic [68:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic ifr, lsr, we, fl, mg, mv);
        bus.if_req     = ifr;
        bus.ls_req     = lsr;
        bus.ls_we      = we;
        bus.if_flush   = fl;
        bus.mem_gnt    = mg;
        bus.mem_rvalid = mv;
    endtask

    task automatic step(input string nm, input logic ifr, lsr, we, fl, mg, mv,
                        input logic [4:0] exp);
        @(negedge clk);
        drive(ifr, lsr, we, fl, mg, mv);
        #1;
        chk(nm, 69'(outs()), 69'(exp));
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        bus.if_addr   = 32'h40;
        bus.ls_addr   = 32'h100;
        bus.ls_wdata  = 32'h1234_5678;
        bus.ls_be     = 4'hF;
        bus.mem_rdata = 32'hA5A5_5A5A;

        //             ifr lsr we fl mg mv  ls_addr      be     exp       addr     we  be
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 32'h100, 4'hF, 5'b00000, 32'h0,   0, 4'h0};
        vecs[1]  = '{0, 1, 0, 0, 0, 0, 32'h100, 4'hF, 5'b00000, 32'h0,   0, 4'h0};
        vecs[2]  = '{0, 1, 0, 0, 1, 0, 32'h100, 4'hF, 5'b10100, 32'h100, 0, 4'hF};
        vecs[3]  = '{0, 0, 0, 0, 1, 1, 32'h100, 4'hF, 5'b00001, 32'h0,   0, 4'h0};
        vecs[4]  = '{1, 1, 1, 0, 0, 0, 32'h200, 4'h3, 5'b00000, 32'h0,   0, 4'h0};
        vecs[5]  = '{1, 1, 1, 0, 1, 0, 32'h200, 4'h3, 5'b10100, 32'h200, 1, 4'h3};
        vecs[6]  = '{1, 0, 0, 0, 0, 1, 32'h200, 4'h3, 5'b00001, 32'h0,   0, 4'h0};
        vecs[7]  = '{1, 0, 0, 0, 0, 0, 32'h200, 4'h3, 5'b00000, 32'h0,   0, 4'h0};
        vecs[8]  = '{1, 0, 0, 0, 1, 0, 32'h200, 4'h3, 5'b11000, 32'h40,  0, 4'hF};
        vecs[9]  = '{0, 0, 0, 0, 0, 1, 32'h200, 4'h3, 5'b00010, 32'h0,   0, 4'h0};
        vecs[10] = '{0, 0, 0, 0, 0, 1, 32'h200, 4'h3, 5'b00000, 32'h0,   0, 4'h0};
        vecs[11] = '{1, 0, 0, 0, 0, 0, 32'h200, 4'h3, 5'b00000, 32'h0,   0, 4'h0};
        vecs[12] = '{1, 0, 0, 0, 0, 1, 32'h200, 4'h3, 5'b10000, 32'h40,  0, 4'hF};
        vecs[13] = '{1, 0, 0, 0, 1, 0, 32'h200, 4'h3, 5'b11000, 32'h40,  0, 4'hF};
        vecs[14] = '{0, 0, 0, 1, 0, 1, 32'h200, 4'h3, 5'b00000, 32'h0,   0, 4'h0};
        vecs[15] = '{0, 1, 0, 0, 0, 0, 32'h100, 4'hF, 5'b00000, 32'h0,   0, 4'h0};
        vecs[16] = '{0, 1, 0, 1, 1, 0, 32'h100, 4'hF, 5'b10100, 32'h100, 0, 4'hF};
        vecs[17] = '{0, 0, 0, 1, 0, 1, 32'h100, 4'hF, 5'b00001, 32'h0,   0, 4'h0};
        vecs[18] = '{1, 0, 0, 0, 0, 0, 32'h100, 4'hF, 5'b00000, 32'h0,   0, 4'h0};
        vecs[19] = '{1, 0, 0, 0, 1, 0, 32'h100, 4'hF, 5'b11000, 32'h40,  0, 4'hF};
        vecs[20] = '{0, 0, 0, 0, 0, 1, 32'h100, 4'hF, 5'b00010, 32'h0,   0, 4'h0};

        // Reset state, checked while reset is still held.
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outs", 69'(outs()), 69'(0));
        chk("reset_fields", 69'({bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.mem_we}), 69'(0));
        chk("reset_rdata", 69'(bus.rdata), 69'(32'hA5A5_5A5A));
        @(negedge clk);
        rst = 1'b0;

        // Directed vector table.
        bus.mem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            bus.ls_addr = vecs[i].ls_addr;
            bus.ls_be   = vecs[i].ls_be;
            drive(vecs[i].ifr, vecs[i].lsr, vecs[i].we, vecs[i].fl, vecs[i].mg, vecs[i].mv);
            #1;
            chk($sformatf("vec%0d", i), 69'(outs()), 69'(vecs[i].exp));
            if (vecs[i].exp[4])
                chk($sformatf("vec%0d_fields", i),
                    69'({bus.mem_addr, bus.mem_we, bus.mem_be}),
                    69'({vecs[i].exp_addr, vecs[i].exp_we, vecs[i].exp_be}));
            if (vecs[i].exp[1:0] != 2'b00)
                chk($sformatf("vec%0d_rdata", i), 69'(bus.rdata), 69'(32'hDEAD_BEEF));
        end

        // Starvation: both requesters always asking, zero-wait memory.
        do_reset();
        drive(1, 1, 0, 0, 1, 1);
        n = 0;
        for (int c = 0; c < 60 && n < 10; c++) begin
            #1;
            if (bus.if_gnt || bus.ls_gnt) begin
                chk($sformatf("starve_grant%0d", n), 69'({bus.if_gnt, bus.ls_gnt}),
                    69'((n % 5 == 4) ? 2'b10 : 2'b01));
                n++;
            end
            @(negedge clk);
        end
        if (n < 10) chk("starve_timeout", 69'(n), 69'(10));

        // Fetch with delayed grant, flushed while waiting for data.
        do_reset();
        bus.if_addr = 32'h80;
        step("flush_idle",  1, 0, 0, 0, 0, 0, 5'b00000);
        step("flush_wait1", 1, 0, 0, 0, 0, 0, 5'b10000);
        step("flush_wait2", 1, 0, 0, 0, 0, 0, 5'b10000);
        step("flush_gnt",   1, 0, 0, 0, 1, 0, 5'b11000);
        step("flush_pulse", 0, 0, 0, 1, 0, 0, 5'b00000);
        step("flush_resp",  0, 0, 0, 0, 0, 1, 5'b00000);
        step("flush_next0", 0, 1, 0, 0, 0, 0, 5'b00000);
        step("flush_next1", 0, 1, 0, 0, 1, 0, 5'b10100);
        step("flush_next2", 0, 0, 0, 0, 0, 1, 5'b00001);

        // Reset in the middle of a store, then a late memory response.
        bus.ls_addr  = 32'h300;
        bus.ls_wdata = 32'h55;
        bus.ls_be    = 4'h3;
        step("rst_idle", 0, 1, 1, 0, 0, 0, 5'b00000);
        step("rst_req",  0, 1, 1, 0, 1, 0, 5'b10100);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk("rst_mid_outs", 69'(outs()), 69'(0));
        chk("rst_mid_fields", 69'({bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.mem_we}), 69'(0));
        @(negedge clk);
        rst = 1'b0;
        step("rst_late_rv", 0, 0, 0, 0, 0, 1, 5'b00000);
        step("rst_quiet",   0, 0, 0, 0, 0, 0, 5'b00000);

        // Randomized traffic against the reference model.
        do_reset();
        m_busy = 0; m_granted = 0; m_own_if = 0; m_dropped = 0; m_streak = 0;
        m_addr = 0; m_wdata = 0; m_be = 0; m_we = 0;
        if_hold = 0; ls_hold = 0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if (!if_hold && $urandom_range(0, 2) == 0) begin
                if_hold     = 1;
                bus.if_addr = $urandom;
            end
            if (!ls_hold && $urandom_range(0, 1) == 0) begin
                ls_hold      = 1;
                bus.ls_we    = 1'($urandom);
                bus.ls_addr  = $urandom;
                bus.ls_wdata = $urandom;
                bus.ls_be    = 4'($urandom);
            end
            bus.if_req     = if_hold;
            bus.ls_req     = ls_hold;
            bus.if_flush   = ($urandom_range(0, 7) == 0);
            bus.mem_gnt    = 1'($urandom);
            bus.mem_rvalid = (m_busy && m_granted) ? 1'($urandom)
                                                   : ($urandom_range(0, 15) == 0);
            bus.mem_rdata  = $urandom;
            #1;
            e[4] = m_busy && !m_granted;
            e[3] = e[4] && m_own_if && bus.mem_gnt;
            e[2] = e[4] && !m_own_if && bus.mem_gnt;
            e[1] = m_busy && m_granted && m_own_if && bus.mem_rvalid
                   && !m_dropped && !bus.if_flush;
            e[0] = m_busy && m_granted && !m_own_if && bus.mem_rvalid;
            chk($sformatf("rnd%0d", c), 69'(outs()), 69'(e));
            if (e[4])
                chk($sformatf("rnd%0d_fields", c),
                    {bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.mem_we},
                    {m_addr, m_wdata, m_be, m_we});
            if (e[1] || e[0])
                chk($sformatf("rnd%0d_rdata", c), 69'(bus.rdata), 69'(bus.mem_rdata));
            if (e[3]) if_hold = 0;
            if (e[2]) ls_hold = 0;

            // Advance the model across the coming clock edge.
            if (!m_busy) begin
                if (!bus.if_req) m_streak = 0;
                if (bus.if_req || bus.ls_req) begin
                    m_own_if = bus.if_req && (!bus.ls_req || m_streak == LIMIT);
                    if (m_own_if) begin
                        m_streak = 0;
                        m_addr   = bus.if_addr;
                        m_wdata  = 0;
                        m_be     = 4'hF;
                        m_we     = 0;
                    end else begin
                        if (bus.if_req) m_streak++;
                        m_addr  = bus.ls_addr;
                        m_wdata = bus.ls_wdata;
                        m_be    = bus.ls_be;
                        m_we    = bus.ls_we;
                    end
                    m_busy    = 1;
                    m_granted = 0;
                    m_dropped = 0;
                end
            end else begin
                if (m_own_if && bus.if_flush) m_dropped = 1;
                if (!m_granted) begin
                    if (bus.mem_gnt) m_granted = 1;
                end else if (bus.mem_rvalid) begin
                    m_busy = 0;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: max consecutive load/store grants while fetch waits (1..7).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 if_req  input  1  fetch request; held with if_addr until if_gnt.
REQ-005 if_addr  input  32  fetch word address.
REQ-006 if_flush  input  1  discard any in-flight fetch response (branch/jump redirect).
REQ-007 if_gnt  output  1  one-cycle pulse: fetch request accepted by memory.
REQ-008 if_rvalid  output  1  one-cycle pulse: fetch data valid on rdata.
REQ-009 ls_req  input  1  load/store request; held with ls_* fields until ls_gnt.
REQ-010 ls_we  input  1  1 store, 0 load.
REQ-011 ls_addr  input  32  load/store byte address.
REQ-012 ls_wdata  input  32  store data.
REQ-013 ls_be  input  4  store byte enables.
REQ-014 ls_gnt  output  1  one-cycle pulse: load/store accepted by memory.
REQ-015 ls_rvalid  output  1  one-cycle pulse: load data valid / store acknowledged.
REQ-016 rdata  output  32  response data, shared by both requesters, = mem_rdata.
REQ-017 mem_req  output  1  request to single-ported memory.
REQ-018 mem_we / mem_addr / mem_wdata / mem_be  output  1/32/32/4  latched request fields.
REQ-019 mem_gnt  input  1  memory accepts request this cycle when mem_req=1.
REQ-020 mem_rvalid  input  1  memory response (read data or write ack), one per accepted request.
REQ-021 mem_rdata  input  32  memory read data.

Function
REQ-022 States IDLE, REQ, RESP; at most one outstanding memory transaction.
REQ-023 IDLE: no request -> stay; else pick owner, latch owner fields into mem_* registers, -> REQ next cycle (mem_req rises one cycle after req sampled).
REQ-024 Priority: load/store wins, except fetch wins when if_req=1 and streak==STARVE_LIMIT.
REQ-025 streak (3-bit): +1 on each LS grant while if_req=1; cleared on fetch grant or if_req=0 in IDLE; never exceeds STARVE_LIMIT.
REQ-026 Fetch latch: mem_we=0, mem_be=4'hF, mem_wdata=0, mem_addr=if_addr.
REQ-027 REQ: mem_req=1 with stable fields; on mem_gnt=1 pulse owner gnt same cycle, -> RESP; mem_req=0 from next cycle.
REQ-028 RESP: on mem_rvalid=1 pulse owner rvalid same cycle (rdata=mem_rdata), -> IDLE; mem_rvalid in IDLE/REQ ignored.
REQ-029 Fetch drop: if_flush=1 while owner=fetch in REQ or RESP sets drop; transaction still completes to memory, if_rvalid suppressed; if_gnt still pulses.
REQ-030 if_flush in same cycle as fetch mem_rvalid suppresses that if_rvalid; drop cleared on return to IDLE; if_flush has no effect on LS transactions or in IDLE.
REQ-031 Minimum turnaround: IDLE->REQ->RESP->IDLE, 3 cycles with zero-wait memory; no back-to-back bypass.
REQ-032 gnt and rvalid never asserted to the non-owner; never both owners same cycle.

Reset
REQ-033 rst=1 asynchronously: state IDLE, streak 0, drop 0, mem_req/mem_we/if_gnt/ls_gnt/if_rvalid/ls_rvalid 0, mem_addr/mem_wdata/mem_be 0; rdata follows mem_rdata.
REQ-034 Reset mid-transaction abandons it; late mem_rvalid after reset ignored (arbiter in IDLE).

Verification
REQ-035 Single load: ls_req, ls_addr=0x100, zero-wait memory, mem_rdata=0xDEADBEEF -> mem_req cycles 1, ls_gnt cycle 1, ls_rvalid cycle 2 with rdata=0xDEADBEEF.
REQ-036 Simultaneous if_req and ls_req (store, be=4'b0011) -> LS first, mem_we=1, mem_be=4'b0011; fetch granted on next IDLE.
REQ-037 Continuous ls_req and if_req, STARVE_LIMIT=4 -> grant order LS,LS,LS,LS,IF,LS,... repeating.
REQ-038 Fetch with mem_gnt delayed 3 cycles, if_flush pulsed in RESP -> mem_req held 3 cycles, if_gnt pulses, if_rvalid never asserted, next request proceeds normally.
REQ-039 rst asserted during RESP, then mem_rvalid=1 after release -> no rvalid to either side, state IDLE, all outputs 0.
